seg_scan_ctrl: RTL
==================

# seg_scan_ctrl

Time-multiplexing scan controller for the 8-digit common-anode seven-segment display. It holds a 16-bit value and walks the digits one at a time, driving active-low anodes and a 5-bit digit code per slot. Optional signed display and leading-zero blanking are supported. It sits between the ALU result path and the digit-to-cathode mapping: `digit_holder` feeds the mapping block, and `an` drives the board anodes directly. Value updates are frame-synchronous, so a new result never tears mid-scan.

## Interface
- `NUM_DIGITS`, 8: number of anodes scanned. Must be greater than `DATA_W/4`.
- `DATA_W`, 16: displayed value width, as 4 hex nibbles.
- `REFRESH_DIV`, 100000: clock cycles per digit slot (1 kHz per digit at 100 MHz). Must be at least 2.
- `clk`, input, 1: single clock; all state is updated on its rising edge.
- `reset`, input, 1: synchronous, active-high.
- `en`, input, 1: scan enable. When low, the display is dark and the counters hold.
- `value`, input, `DATA_W`: value to display.
- `load`, input, 1: one-cycle strobe that captures `value`.
- `signed_mode`, input, 1: sampled with `load`. When 1, `value` is two's complement.
- `blank_lz`, input, 1: sampled with `load`. When 1, leading zeros are blanked.
- `an`, output, `NUM_DIGITS`: active-low anode enables, one-hot-low while scanning.
- `digit_holder`, output, 5: digit code. 0–15 are hex digits, 16 is blank, 17 is minus.
- `frame_done`, output, 1: one-cycle pulse when the scan wraps from the last digit to digit 0.

## Operation
- **Prescaler:** `pcnt` counts 0 to `REFRESH_DIV-1`. At terminal count it returns to 0 and the slot index `idx` advances: `idx+1`, wrapping `NUM_DIGITS-1` to 0.
- **Registers:**
  - shadow: `sh_val`, `sh_sgn`, `sh_lz`, plus a `pending` flag.
  - active: `act_val`, `act_sgn`, `act_lz`.
- **`load` outside a frame boundary:** the shadow registers capture the inputs and `pending` is set to 1. If `load` arrives while already pending, the last value wins.
- **Frame boundary** (the `idx` wrap cycle):
  - If `load` is high in that same cycle, the inputs go straight to the active registers and `pending` is cleared.
  - Otherwise, if `pending` is set, shadow is copied to active and `pending` is cleared.
  - `frame_done` pulses in either case.
- **Magnitude:** `mag = (act_sgn && act_val[DATA_W-1]) ? -act_val : act_val`, computed in `DATA_W` bits. 0x8000 therefore yields a magnitude of 0x8000.
- **Significant digits:** `sig` is the index of the highest nonzero nibble of `mag`, plus 1. The minimum is 1, so zero displays as "0".
- **Code for slot i:**
  - i < `DATA_W/4` and (`!act_lz` or i < `sig`): nibble i of `mag`.
  - i == `sig` and the value is negative: 17 (minus). The minus is placed at `sig` regardless of `act_lz`.
  - Otherwise: 16 (blank).
- **`en` low:** `an` is all ones, `digit_holder` is 16, and `pcnt`/`idx` hold. `load` still captures into shadow. No frame boundary occurs.

## Timing
- **Reset values:**
  - `an` = all ones, `digit_holder` = 16, `frame_done` = 0.
  - `pcnt` = 0, `idx` = 0, `pending` = 0.
  - active and shadow: value 0, sign 0, lz 1.
- **Output registering:** `an` and `digit_holder` are registered from (`idx`, active). They change together, one cycle after `idx` changes. `an[idx]` = 0 and all other bits are 1.
- **First slot after reset:** the first cycle after `reset` deasserts (with `en`=1) shows `an` = 8'b11111110 and `digit_holder` = 0.
- **Slot and frame length:** each slot lasts exactly `REFRESH_DIV` cycles. A frame is `NUM_DIGITS*REFRESH_DIV` cycles.
- **`frame_done`:** asserted in the cycle after the wrap, aligned with the first `an` update to digit 0.
- **Load-to-display latency:** at most one full frame plus 1 cycle.
- **Reset mid-frame:** everything returns to reset values immediately. A pending load is discarded.

## Structure
- **Package `seg_pkg`:**
  - `SEG_CODE_W` = 5
  - `SEG_BLANK` = 5'd16
  - `SEG_MINUS` = 5'd17
  - the hex code range, shared with the mapping block.
- **Sub-module `seg_digit_select`:** combinational. It maps (`act_val`, `act_sgn`, `act_lz`, `idx`) to a code: magnitude, significant-digit count and minus placement.
- **`seg_scan_ctrl`:** owns the prescaler, index, shadow/pending logic and output registers. It does not instantiate the cathode mapping; the top level wires `digit_holder` to it.

## Test plan
All scenarios use `REFRESH_DIV`=4, so each frame is 32 cycles.
- **Reset and scan:** after reset, with `en`=1 → `an` walks 0xFE, 0xFD, …, 0x7F with each slot held 4 cycles; `digit_holder` is 0 for slot 0 and 16 elsewhere; `frame_done` pulses every 32 cycles.
- **Signed negative:** `load` `value`=0xFFF6 with `signed_mode`=1, `blank_lz`=1 → after the next boundary, slots 0..7 show 10, 17, 16, 16, 16, 16, 16, 16 ("-A").
- **Worst-case magnitude:** `value`=0x8000, signed, no blanking → slots 0..4 show 0, 0, 0, 8, 17.
- **Frame-synchronous update:** `load` 0x1234 mid-frame, then `load` 0x00AB before the boundary → no change until the wrap, then slots 0..3 show 11, 10, 16, 16 (blanked). 0x1234 is never displayed.
- **Load on the boundary cycle:** `load` in the exact wrap cycle → new value visible on slot 0 of that frame, and `pending` = 0 afterwards.
- **Enable and reset:** `en`=0 for 10 cycles → `an` = 0xFF, `digit_holder` = 16, `pcnt`/`idx` frozen, and the scan resumes at the same slot. Separately, `reset` pulsed mid-frame with a load pending → display returns to "0" and the pending load is dropped.

Source files
------------

// File: rtl/seg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seg_pkg : digit-code constants shared by the scan and cathode blocks |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package seg_pkg;

  localparam int SEG_CODE_W = 5;

  // Codes 0..15 are hex digits; the two codes above them are the glyphs.
  localparam logic [SEG_CODE_W-1:0] SEG_HEX_MIN = 5'd0;
  localparam logic [SEG_CODE_W-1:0] SEG_HEX_MAX = 5'd15;
  localparam logic [SEG_CODE_W-1:0] SEG_BLANK   = 5'd16;
  localparam logic [SEG_CODE_W-1:0] SEG_MINUS   = 5'd17;

endpackage
`default_nettype wire

// File: rtl/seg_digit_select.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seg_digit_select : value/sign/blanking + slot index -> digit code     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module seg_digit_select
  import seg_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int IDX_W  = 3
) (
  input  logic [DATA_W-1:0]     act_val_i,
  input  logic                  act_sgn_i,
  input  logic                  act_lz_i,
  input  logic [IDX_W-1:0]      idx_i,
  output logic [SEG_CODE_W-1:0] code_o
);

  localparam int NIBBLES = DATA_W / 4;

  logic              neg;
  logic [DATA_W-1:0] mag;
  logic [3:0]        nib;
  int                sig;
  int                slot;

  always_comb begin
    neg  = act_sgn_i & act_val_i[DATA_W-1];
    // Negating the most negative value wraps back onto itself, which is
    // exactly the magnitude we want to show.
    mag  = neg ? (~act_val_i + DATA_W'(1)) : act_val_i;
    slot = int'(idx_i);
    sig  = 1;
    nib  = 4'd0;
    for (int n = 0; n < NIBBLES; n++) begin
      if (mag[n*4 +: 4] != 4'd0) sig = n + 1;
      if (n == slot)             nib = mag[n*4 +: 4];
    end

    code_o = SEG_BLANK;
    if (slot < NIBBLES && (!act_lz_i || slot < sig)) begin
      code_o = {1'b0, nib};
    end else if (slot == sig && neg) begin
      code_o = SEG_MINUS;
    end
  end

endmodule
`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seg_scan_ctrl : 7-seg anode scanner with frame-synchronous updates   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 8,
  parameter int DATA_W      = 16,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  en_i,
  input  logic [DATA_W-1:0]     value_i,
  input  logic                  load_i,
  input  logic                  signed_mode_i,
  input  logic                  blank_lz_i,
  output logic [NUM_DIGITS-1:0] an_o,
  output logic [SEG_CODE_W-1:0] digit_holder_o,
  output logic                  frame_done_o
);

  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PCNT_W = $clog2(REFRESH_DIV);
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  logic [PCNT_W-1:0]     pcnt_q, pcnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_W-1:0]     sh_val_q, sh_val_d, act_val_q, act_val_d;
  logic                  sh_sgn_q, sh_sgn_d, act_sgn_q, act_sgn_d;
  logic                  sh_lz_q, sh_lz_d, act_lz_q, act_lz_d;
  logic                  pending_q, pending_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [SEG_CODE_W-1:0] dig_q, dig_d;
  logic                  wrap_q, wrap_d;
  logic                  fd_q, fd_d;

  logic                  slot_end;
  logic                  wrap;
  logic [SEG_CODE_W-1:0] code;

  seg_digit_select #(
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_digit_select (
    .act_val_i (act_val_q),
    .act_sgn_i (act_sgn_q),
    .act_lz_i  (act_lz_q),
    .idx_i     (idx_q),
    .code_o    (code)
  );

  always_comb begin
    slot_end  = en_i && (pcnt_q == PCNT_LAST);
    wrap      = slot_end && (idx_q == IDX_LAST);

    pcnt_d    = pcnt_q;
    idx_d     = idx_q;
    sh_val_d  = sh_val_q;
    sh_sgn_d  = sh_sgn_q;
    sh_lz_d   = sh_lz_q;
    act_val_d = act_val_q;
    act_sgn_d = act_sgn_q;
    act_lz_d  = act_lz_q;
    pending_d = pending_q;

    if (en_i) pcnt_d = slot_end ? '0 : pcnt_q + PCNT_W'(1);
    if (slot_end) idx_d = wrap ? '0 : idx_q + IDX_W'(1);

    // A load landing on the wrap cycle bypasses the shadow entirely.
    if (wrap) begin
      if (load_i) begin
        act_val_d = value_i;
        act_sgn_d = signed_mode_i;
        act_lz_d  = blank_lz_i;
      end else if (pending_q) begin
        act_val_d = sh_val_q;
        act_sgn_d = sh_sgn_q;
        act_lz_d  = sh_lz_q;
      end
      pending_d = 1'b0;
    end else if (load_i) begin
      sh_val_d  = value_i;
      sh_sgn_d  = signed_mode_i;
      sh_lz_d   = blank_lz_i;
      pending_d = 1'b1;
    end

    an_d   = en_i ? ~(NUM_DIGITS'(1) << idx_q) : '1;
    dig_d  = en_i ? code : SEG_BLANK;
    wrap_d = wrap;
    fd_d   = wrap_q;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pcnt_q    <= '0;
      idx_q     <= '0;
      sh_val_q  <= '0;
      sh_sgn_q  <= 1'b0;
      sh_lz_q   <= 1'b1;
      act_val_q <= '0;
      act_sgn_q <= 1'b0;
      act_lz_q  <= 1'b1;
      pending_q <= 1'b0;
      an_q      <= '1;
      dig_q     <= SEG_BLANK;
      wrap_q    <= 1'b0;
      fd_q      <= 1'b0;
    end else begin
      pcnt_q    <= pcnt_d;
      idx_q     <= idx_d;
      sh_val_q  <= sh_val_d;
      sh_sgn_q  <= sh_sgn_d;
      sh_lz_q   <= sh_lz_d;
      act_val_q <= act_val_d;
      act_sgn_q <= act_sgn_d;
      act_lz_q  <= act_lz_d;
      pending_q <= pending_d;
      an_q      <= an_d;
      dig_q     <= dig_d;
      wrap_q    <= wrap_d;
      fd_q      <= fd_d;
    end
  end

  assign an_o           = an_q;
  assign digit_holder_o = dig_q;
  assign frame_done_o   = fd_q;

endmodule
`default_nettype wire
